// File: rtl/vga_vmem_reader.sv
// VGA 640x480@60 scan-out of the 32x32 colour-cell video memory.
// Two-tick pipeline: counters -> read address / sync / visibility -> RGB and sync pins.
module vga_vmem_reader #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CELL_W    = 20,
  parameter int CELL_H    = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPixelEnable,
  output logic [9:0] oReadAddress,
  input  logic [2:0] iReadData,
  output logic       oRed,
  output logic       oGreen,
  output logic       oBlue,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oFrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [4:0] XSUB_LAST = 5'(CELL_W - 1);
  localparam logic [4:0] YSUB_LAST = 5'(CELL_H - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic [4:0] xsub_q, xsub_d;
  logic [4:0] col_q, col_d;
  logic [4:0] ysub_q, ysub_d;
  logic [4:0] row_q, row_d;
  logic       h_wrap, v_wrap, h_vis, v_vis;

  logic [9:0] addr_p1_q;
  logic       vis_p1_q, hs_p1_q, vs_p1_q;
  logic [2:0] rgb_p2_q;
  logic       hs_p2_q, vs_p2_q;
  logic       frame_q;

  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = h_wrap && (vcount_q == V_LAST);
    h_vis    = (hcount_q < H_VIS);
    v_vis    = (vcount_q < V_VIS);

    hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
    end

    // col rolls 31 -> 0 on the last visible pixel, so blanking reads cell column 0
    xsub_d = xsub_q;
    col_d  = col_q;
    if (h_wrap) begin
      xsub_d = 5'd0;
      col_d  = 5'd0;
    end else if (h_vis) begin
      if (xsub_q == XSUB_LAST) begin
        xsub_d = 5'd0;
        col_d  = col_q + 5'd1;
      end else begin
        xsub_d = xsub_q + 5'd1;
      end
    end

    ysub_d = ysub_q;
    row_d  = row_q;
    if (v_wrap) begin
      ysub_d = 5'd0;
      row_d  = 5'd0;
    end else if (h_wrap && v_vis) begin
      if (ysub_q == YSUB_LAST) begin
        ysub_d = 5'd0;
        row_d  = row_q + 5'd1;
      end else begin
        ysub_d = ysub_q + 5'd1;
      end
    end
  end

  // Stage 0: raster and cell counters
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
      xsub_q   <= 5'd0;
      col_q    <= 5'd0;
      ysub_q   <= 5'd0;
      row_q    <= 5'd0;
    end else if (iPixelEnable) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      xsub_q   <= xsub_d;
      col_q    <= col_d;
      ysub_q   <= ysub_d;
      row_q    <= row_d;
    end
  end

  // Stage 1: memory address, visibility and raw sync levels
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_p1_q <= 10'd0;
      vis_p1_q  <= 1'b0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
    end else if (iPixelEnable) begin
      addr_p1_q <= {row_q, col_q};
      vis_p1_q  <= h_vis && v_vis;
      hs_p1_q   <= !((hcount_q >= HS_START) && (hcount_q < HS_END));
      vs_p1_q   <= !((vcount_q >= VS_START) && (vcount_q < VS_END));
    end
  end

  // Stage 2: colour from memory, sync delayed to stay aligned with it
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rgb_p2_q <= 3'b000;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
    end else if (iPixelEnable) begin
      rgb_p2_q <= vis_p1_q ? iReadData : 3'b000;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
    end
  end

  // Frame strobe is a single Clock wide even when the pixel tick is slower
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= iPixelEnable && v_wrap;
    end
  end

  assign oReadAddress = addr_p1_q;
  assign oRed         = rgb_p2_q[2];
  assign oGreen       = rgb_p2_q[1];
  assign oBlue        = rgb_p2_q[0];
  assign oHSync       = hs_p2_q;
  assign oVSync       = vs_p2_q;
  assign oFrameStart  = frame_q;

endmodule

// File: doc/vga_vmem_reader.md
Name: vga_vmem_reader

Overview:
- Read side of the video memory that the CPU fills with `WVM` writes.
- Generates 640x480@60 VGA timing and scans the 32x32-cell colour grid (address = row*32 + col, 1024 entries, 3-bit colour).
- Fetches each cell's colour from the synchronous-read port of video memory and drives the RGB and sync pins.
- Issues a per-frame strobe the CPU side uses for pacing the game loop.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CELL_W, 20, pixels per grid cell horizontally
CELL_H, 15, lines per grid cell vertically

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-high reset
iPixelEnable  input  1  pixel tick; all state advances only when high
oReadAddress  output  10  video memory read address {row[4:0], col[4:0]}
iReadData  input  3  colour from video memory, valid 1 Clock after address; bit2=R, bit1=G, bit0=B
oRed  output  1  red pin
oGreen  output  1  green pin
oBlue  output  1  blue pin
oHSync  output  1  horizontal sync, active low
oVSync  output  1  vertical sync, active low
oFrameStart  output  1  one-Clock pulse at the start of each frame

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - hcount, vcount, xsub, col, ysub and row are 0.
  - oReadAddress is 0.
  - oRed, oGreen and oBlue are 0.
  - oHSync and oVSync are 1 (inactive).
  - oFrameStart is 0 and all pipeline valid/sync delay registers are cleared.
- Every register except oFrameStart changes only on a Clock edge with iPixelEnable=1.
- hcount runs 0..H_TOTAL-1 (800), then wraps to 0. On each wrap, vcount increments; vcount runs 0..V_TOTAL-1 (525), then wraps to 0.
- Horizontal cell counters: while hcount < H_VISIBLE, xsub counts 0..CELL_W-1. When xsub = CELL_W-1 it wraps to 0 and col increments. xsub and col are forced to 0 when hcount wraps.
- Vertical cell counters: ysub/row advance only at a line wrap while vcount < V_VISIBLE. When ysub = CELL_H-1 it wraps to 0 and row increments. ysub and row are forced to 0 when vcount wraps to 0.
- Pipeline, measured in enabled ticks:
  - Stage 1 (tick n+1) registers:
    - oReadAddress <= {row, col}
    - vis1 <= (hcount < H_VISIBLE && vcount < V_VISIBLE)
    - hs1 <= !(hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1])
    - vs1 from vcount in the same form.
  - Stage 2 (tick n+2) registers:
    - {oRed, oGreen, oBlue} <= vis1 ? iReadData : 3'b000
    - oHSync <= hs1, oVSync <= vs1.
  - Colour and sync therefore share a fixed 2-tick latency from the counters and stay aligned.
- Memory contract: iReadData must reflect oReadAddress one Clock after it changes. This holds for any iPixelEnable duty cycle, including iPixelEnable tied high.
- Blanking: colour outputs are 0 regardless of iReadData. oReadAddress holds the last {row,col} computed (col=0 after line wrap).
- oFrameStart: high for exactly one Clock on the enabled edge where hcount and vcount both wrap to 0. Low otherwise, including every cycle with iPixelEnable=0.
- Widths: hcount and vcount are 10 bits; xsub and ysub are 5 bits. col and row are 5 bits and cannot exceed 31, since 640/20 = 480/15 = 32.
- Reset asserted mid-frame: all outputs take their reset values immediately. After release, the first enabled tick restarts at hcount=vcount=0 with no frame-start pulse for that restart.

Test Plan:
- iPixelEnable tied high, 2 frames -> oHSync low for 96 Clocks per 800; falling edge 658 Clocks after line start (656 + 2 latency). oVSync low for 1600 Clocks per 420000. oFrameStart pulses every 420000 Clocks.
- Memory model returns iReadData = address[2:0]; observe first visible line -> oReadAddress steps 0,1,2,...,31, holding each value 20 ticks. RGB shows the same values 1 tick later.
- Line 15 and line 479 -> oReadAddress starts at 32 and 992 respectively. oReadAddress reaches 1023 at the last cell of line 479.
- iReadData forced to 3'b111 throughout -> RGB=000 for all ticks with hcount>=640 or vcount>=480. Otherwise RGB=111, i.e. oRed=oGreen=oBlue=1.
- iPixelEnable toggling 1,0,1,0 -> all periods double in Clock units (hsync low 192 Clocks). oFrameStart stays a single-Clock pulse.
- Reset pulsed at hcount=300, vcount=200 -> outputs go to reset values asynchronously, before the next Clock. After release, line and frame timing restart from 0.
